home_inventory_adc_seq: RTL and testbench

Frame sequencer for the shared ADC front-end, sitting between the Wishbone register block and the ADC interface. It turns snapshot commands, CTRL.START and a periodic timer into per-channel conversion requests on one req/ack port. It writes each sign-extended result into the ADC_RAW register bank and reports frame completion, frame count and timeout errors back to STATUS and IRQ logic.

---
 rtl/home_inventory_adc_seq_pkg.sv | 23 ++
 rtl/home_inventory_adc_seq_if.sv | 24 ++
 rtl/home_inventory_period_timer.sv | 38 +++
 rtl/home_inventory_adc_seq.sv | 184 ++++++++++++++++++
 tb/tb_home_inventory_adc_seq.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/home_inventory_adc_seq_pkg.sv
// Shared definitions for the ADC frame sequencer: FSM encoding, the sample
// written when a channel times out, and the NUM_CH clamp rule.
package home_inventory_adc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [31:0] TIMEOUT_SAMPLE = 32'h8000_0000;

    // A zero or out-of-range channel count means "use every slot".
    function automatic logic [3:0] clamp_num_ch(input logic [3:0] num_ch,
                                                input logic [3:0] num_max);
        if (num_ch == 4'd0 || num_ch > num_max) begin
            return num_max;
        end
        return num_ch;
    endfunction

endpackage

// File: rtl/home_inventory_adc_seq_if.sv
// Conversion req/ack port plus the ADC_RAW write port of the frame sequencer.
interface home_inventory_adc_seq_if #(
    parameter int DATA_W = 24
) ();

    logic              conv_req_o;
    logic [2:0]        conv_ch_o;
    logic              conv_ack_i;
    logic [DATA_W-1:0] conv_data_i;
    logic              raw_we_o;
    logic [2:0]        raw_ch_o;
    logic [31:0]       raw_data_o;

    modport master (
        output conv_req_o, conv_ch_o, raw_we_o, raw_ch_o, raw_data_o,
        input  conv_ack_i, conv_data_i
    );

    modport slave (
        input  conv_req_o, conv_ch_o, raw_we_o, raw_ch_o, raw_data_o,
        output conv_ack_i, conv_data_i
    );

endinterface

// File: rtl/home_inventory_period_timer.sv
// Periodic frame trigger: ticks once every cfg_period clocks while enabled.
module home_inventory_period_timer
    import home_inventory_adc_seq_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;
    logic                run;
    logic                wrap;

    assign run  = enable && (period != '0);
    assign wrap = run && (cnt_q == period - PERIOD_W'(1));
    assign tick = wrap;

    always_comb begin
        cnt_d = cnt_q + PERIOD_W'(1);
        if (!run || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/home_inventory_adc_seq.sv
// ADC frame sequencer: walks channels 0..n-1 through the req/ack front-end and
// writes sign-extended results into the ADC_RAW bank, one frame per trigger.
module home_inventory_adc_seq
    import home_inventory_adc_seq_pkg::*;
#(
    parameter int NUM_CH_MAX  = 8,
    parameter int DATA_W      = 24,
    parameter int PERIOD_W    = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     ctrl_enable,
    input  logic                     ctrl_start,
    input  logic                     snapshot_i,
    input  logic [3:0]               cfg_num_ch,
    input  logic [PERIOD_W-1:0]      cfg_period,
    home_inventory_adc_seq_if.master adc,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic [31:0]              frame_cnt_o,
    output logic                     err_timeout_o
);

    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

    seq_state_e        state_q, state_d;
    logic [2:0]        ch_q, ch_d;
    logic [3:0]        n_q, n_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              pending_q, pending_d;
    logic              conv_req_q, conv_req_d;
    logic              raw_we_q, raw_we_d;
    logic [2:0]        raw_ch_q, raw_ch_d;
    logic [31:0]       raw_data_q, raw_data_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;
    logic              err_q, err_d;

    logic              tick;
    logic              trigger;
    logic [31:0]       sample_ext;
    logic              last_ch;

    home_inventory_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .enable (ctrl_enable),
        .period (cfg_period),
        .tick   (tick)
    );

    assign trigger    = snapshot_i | (ctrl_start & ctrl_enable) | tick;
    assign sample_ext = {{(32 - DATA_W){adc.conv_data_i[DATA_W-1]}}, adc.conv_data_i};
    assign last_ch    = ({1'b0, ch_q} == (n_q - 4'd1));

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        n_d          = n_q;
        wait_d       = wait_q;
        pending_d    = pending_q;
        conv_req_d   = conv_req_q;
        raw_we_d     = 1'b0;
        raw_ch_d     = raw_ch_q;
        raw_data_d   = raw_data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    n_d        = clamp_num_ch(cfg_num_ch, 4'(NUM_CH_MAX));
                    ch_d       = 3'd0;
                    wait_d     = '0;
                    conv_req_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (trigger) begin
                    pending_d = 1'b1;
                end
                // A real ack wins over a timeout landing on the same edge.
                if (adc.conv_ack_i) begin
                    raw_data_d = sample_ext;
                    raw_ch_d   = ch_q;
                    raw_we_d   = 1'b1;
                    conv_req_d = 1'b0;
                    state_d    = ST_STORE;
                end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
                    raw_data_d = TIMEOUT_SAMPLE;
                    raw_ch_d   = ch_q;
                    raw_we_d   = 1'b1;
                    conv_req_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = ST_STORE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_STORE: begin
                if (trigger) begin
                    pending_d = 1'b1;
                end
                if (last_ch) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 32'd1;
                    state_d      = ST_DONE;
                end else begin
                    ch_d       = ch_q + 3'd1;
                    wait_d     = '0;
                    conv_req_d = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_DONE: begin
                if (pending_q || trigger) begin
                    n_d        = clamp_num_ch(cfg_num_ch, 4'(NUM_CH_MAX));
                    ch_d       = 3'd0;
                    wait_d     = '0;
                    conv_req_d = 1'b1;
                    pending_d  = 1'b0;
                    state_d    = ST_REQ;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q      <= ST_IDLE;
            ch_q         <= 3'd0;
            n_q          <= 4'd0;
            wait_q       <= '0;
            pending_q    <= 1'b0;
            conv_req_q   <= 1'b0;
            raw_we_q     <= 1'b0;
            raw_ch_q     <= 3'd0;
            raw_data_q   <= 32'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            n_q          <= n_d;
            wait_q       <= wait_d;
            pending_q    <= pending_d;
            conv_req_q   <= conv_req_d;
            raw_we_q     <= raw_we_d;
            raw_ch_q     <= raw_ch_d;
            raw_data_q   <= raw_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
        end
    end

    assign adc.conv_req_o = conv_req_q;
    assign adc.conv_ch_o  = ch_q;
    assign adc.raw_we_o   = raw_we_q;
    assign adc.raw_ch_o   = raw_ch_q;
    assign adc.raw_data_o = raw_data_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = frame_done_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_home_inventory_adc_seq.sv
// Self-checking bench for home_inventory_adc_seq: a front-end responder pushes
// expected ADC_RAW writes into a scoreboard that a monitor pops and compares.
module tb_home_inventory_adc_seq;

    logic        clk;
    logic        rst_n;
    logic        ctrl_enable;
    logic        ctrl_start;
    logic        snapshot;
    logic [3:0]  cfg_num_ch;
    logic [15:0] cfg_period;
    logic        busy;
    logic        frame_done;
    logic [31:0] frame_cnt;
    logic        err_timeout;

    int          n_compared;
    int          n_mismatched;
    int          cycle;
    int          done_count;
    int          raw_writes;
    int          busy_cycles;
    int          ack_delay;
    int          skip_ch;
    int          timeout_len;
    int          exp_frames;
    logic        prev_busy;
    logic [34:0] sb_q[$];
    int          starts[$];

    home_inventory_adc_seq_if #(.DATA_W(24)) adc ();

    home_inventory_adc_seq dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .ctrl_enable   (ctrl_enable),
        .ctrl_start    (ctrl_start),
        .snapshot_i    (snapshot),
        .cfg_num_ch    (cfg_num_ch),
        .cfg_period    (cfg_period),
        .adc           (adc),
        .busy_o        (busy),
        .frame_done_o  (frame_done),
        .frame_cnt_o   (frame_cnt),
        .err_timeout_o (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // kind 0 = snapshot pulse, 1 = ctrl_start pulse
    task automatic applyStimulus(input int kind);
        @(negedge clk);
        if (kind == 0) snapshot = 1'b1;
        else           ctrl_start = 1'b1;
        @(negedge clk);
        snapshot   = 1'b0;
        ctrl_start = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget);
        for (int i = 0; i < budget && done_count < target; i++) @(negedge clk);
        if (done_count < target) checkOutput("done_wait", 32'(done_count), 32'(target));
        repeat (3) @(negedge clk);
    endtask

    // Front-end model: acks after ack_delay request cycles, never acks skip_ch.
    initial begin
        int req_cycles;
        int last_ch;
        logic [23:0] d;
        req_cycles = 0;
        last_ch = -1;
        timeout_len = 0;
        adc.conv_ack_i = 1'b0;
        adc.conv_data_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !adc.conv_req_o) begin
                if (req_cycles != 0 && last_ch == skip_ch) timeout_len = req_cycles;
                adc.conv_ack_i = 1'b0;
                req_cycles = 0;
            end else begin
                if (req_cycles == 0 && int'(adc.conv_ch_o) == skip_ch)
                    sb_q.push_back({adc.conv_ch_o, 32'h8000_0000});
                last_ch = int'(adc.conv_ch_o);
                if (int'(adc.conv_ch_o) != skip_ch && req_cycles == ack_delay) begin
                    d = 24'h80_0001 + 24'(adc.conv_ch_o);
                    adc.conv_ack_i = 1'b1;
                    adc.conv_data_i = d;
                    sb_q.push_back({adc.conv_ch_o, {{8{d[23]}}, d}});
                end
                req_cycles++;
            end
        end
    end

    // Monitor: pops the scoreboard on every raw write and tracks frame events.
    initial begin
        logic [34:0] e;
        done_count = 0;
        raw_writes = 0;
        busy_cycles = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (adc.raw_we_o) begin
                raw_writes++;
                if (sb_q.size() == 0) begin
                    checkOutput("sb_depth", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("raw_ch", {29'd0, adc.raw_ch_o}, {29'd0, e[34:32]});
                    checkOutput("raw_data", adc.raw_data_o, e[31:0]);
                end
            end
            if (frame_done) done_count++;
            if (busy) busy_cycles++;
            if (busy && !prev_busy) starts.push_back(cycle);
            prev_busy = busy;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0, w0, b0, s0, found;
        n_compared = 0;
        n_mismatched = 0;
        exp_frames = 0;
        ack_delay = 1;
        skip_ch = -1;
        rst_n = 1'b0;
        ctrl_enable = 1'b0;
        ctrl_start = 1'b0;
        snapshot = 1'b0;
        cfg_num_ch = 4'd4;
        cfg_period = 16'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_req", {31'd0, adc.conv_req_o}, 32'd0);
        checkOutput("rst_cnt", frame_cnt, 32'd0);
        checkOutput("rst_err", {31'd0, err_timeout}, 32'd0);
        checkOutput("rst_we", {31'd0, adc.raw_we_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] snapshot frame, 4 channels, ack after 1 cycle");
        d0 = done_count; w0 = raw_writes;
        applyStimulus(0);
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
        checkOutput("start_req", {31'd0, adc.conv_req_o}, 32'd1);
        checkOutput("start_ch", {29'd0, adc.conv_ch_o}, 32'd0);
        waitDone(d0 + 1, 100);
        exp_frames++;
        checkOutput("f1_writes", 32'(raw_writes - w0), 32'd4);
        checkOutput("f1_done", 32'(done_count - d0), 32'd1);
        checkOutput("f1_cnt", frame_cnt, 32'(exp_frames));
        checkOutput("f1_idle", {31'd0, busy}, 32'd0);

        $display("[TB] NUM_CH clamp with zero-wait front-end");
        ack_delay = 0;
        for (int k = 0; k < 2; k++) begin
            cfg_num_ch = (k == 0) ? 4'd0 : 4'd9;
            d0 = done_count; w0 = raw_writes; b0 = busy_cycles;
            applyStimulus(0);
            waitDone(d0 + 1, 100);
            exp_frames++;
            checkOutput("clamp_writes", 32'(raw_writes - w0), 32'd8);
            checkOutput("clamp_busy_len", 32'(busy_cycles - b0), 32'd17);
            checkOutput("clamp_cnt", frame_cnt, 32'(exp_frames));
        end

        $display("[TB] ctrl_start gated by enable, then periodic mode");
        d0 = done_count; b0 = busy_cycles;
        applyStimulus(1);
        repeat (20) @(negedge clk);
        checkOutput("gated_done", 32'(done_count - d0), 32'd0);
        checkOutput("gated_busy", 32'(busy_cycles - b0), 32'd0);
        cfg_num_ch = 4'd1;
        s0 = starts.size();
        ctrl_enable = 1'b1;
        cfg_period = 16'd100;
        waitDone(d0 + 3, 400);
        ctrl_enable = 1'b0;
        cfg_period = 16'd0;
        exp_frames += 3;
        checkOutput("per_starts", 32'(starts.size() - s0), 32'd3);
        if (starts.size() >= s0 + 3) begin
            checkOutput("per_gap1", 32'(starts[s0+1] - starts[s0]), 32'd100);
            checkOutput("per_gap2", 32'(starts[s0+2] - starts[s0+1]), 32'd100);
        end
        repeat (150) @(negedge clk);
        checkOutput("per_stopped", frame_cnt, 32'(exp_frames));

        $display("[TB] triggers while busy collapse into one pending frame");
        cfg_num_ch = 4'd8;
        ack_delay = 2;
        d0 = done_count; w0 = raw_writes; b0 = busy_cycles;
        applyStimulus(0);
        for (int k = 0; k < 3; k++) begin
            repeat (4) @(negedge clk);
            applyStimulus(0);
        end
        waitDone(d0 + 2, 200);
        repeat (60) @(negedge clk);
        exp_frames += 2;
        checkOutput("pend_done", 32'(done_count - d0), 32'd2);
        checkOutput("pend_writes", 32'(raw_writes - w0), 32'd16);
        checkOutput("pend_busy_len", 32'(busy_cycles - b0), 32'd66);
        checkOutput("pend_cnt", frame_cnt, 32'(exp_frames));

        $display("[TB] channel 2 never acked");
        cfg_num_ch = 4'd4;
        ack_delay = 0;
        skip_ch = 2;
        d0 = done_count; w0 = raw_writes;
        checkOutput("to_err_before", {31'd0, err_timeout}, 32'd0);
        applyStimulus(0);
        waitDone(d0 + 1, 400);
        exp_frames++;
        checkOutput("to_len", 32'(timeout_len), 32'd255);
        checkOutput("to_err", {31'd0, err_timeout}, 32'd1);
        checkOutput("to_writes", 32'(raw_writes - w0), 32'd4);
        checkOutput("to_cnt", frame_cnt, 32'(exp_frames));
        skip_ch = -1;
        repeat (10) @(negedge clk);
        checkOutput("to_sticky", {31'd0, err_timeout}, 32'd1);

        $display("[TB] reset during channel 3 request");
        cfg_num_ch = 4'd8;
        ack_delay = 3;
        w0 = raw_writes;
        applyStimulus(0);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (adc.conv_req_o && adc.conv_ch_o == 3'd3) found = 1;
            else @(negedge clk);
        end
        checkOutput("reach_ch3", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mrst_req", {31'd0, adc.conv_req_o}, 32'd0);
        checkOutput("mrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mrst_cnt", frame_cnt, 32'd0);
        checkOutput("mrst_err", {31'd0, err_timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("mrst_writes", 32'(raw_writes - w0), 32'd3);
        checkOutput("mrst_sb_empty", 32'(sb_q.size()), 32'd0);
        sb_q.delete();

        $display("[TB] recovery frame after reset");
        exp_frames = 0;
        cfg_num_ch = 4'd2;
        ack_delay = 0;
        d0 = done_count;
        applyStimulus(0);
        waitDone(d0 + 1, 100);
        exp_frames++;
        checkOutput("rec_cnt", frame_cnt, 32'(exp_frames));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
